// File: rtl/prog_load_sequencer_pkg.sv
// Shared types and constants for the program-load sequencer: FSM state encoding,
// frame geometry (length prefix and word size) and the word-range helper.
package prog_load_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 8 * LEN_BYTES;
  localparam int WORD_W     = 8 * WORD_BYTES;
  localparam int BCNT_W     = $clog2(WORD_BYTES);

  // imem and dmem together span 2^(addr_w+1) words; anything above is dropped.
  function automatic logic word_in_range(input logic [LEN_W-1:0] wc, input int addr_w);
    return (wc >> (addr_w + 1)) == '0;
  endfunction

endpackage

// File: rtl/prog_load_sequencer_if.sv
// Bus bundle of the program-load sequencer: UART byte stream, CPU dmem write port
// and the shared imem/dmem write port. The sequencer is the slave side.
interface prog_load_if #(
  parameter int ADDR_W = 14
);

  logic              rx_valid_i;
  logic [7:0]        rx_data_i;
  logic              cpu_wen_i;
  logic [ADDR_W-1:0] cpu_adr_i;
  logic [31:0]       cpu_dat_i;
  logic              imem_wen_o;
  logic              dmem_wen_o;
  logic [ADDR_W-1:0] mem_adr_o;
  logic [31:0]       mem_dat_o;

  modport slave (
    input  rx_valid_i, rx_data_i, cpu_wen_i, cpu_adr_i, cpu_dat_i,
    output imem_wen_o, dmem_wen_o, mem_adr_o, mem_dat_o
  );

  modport master (
    output rx_valid_i, rx_data_i, cpu_wen_i, cpu_adr_i, cpu_dat_i,
    input  imem_wen_o, dmem_wen_o, mem_adr_o, mem_dat_o
  );

endinterface

// File: rtl/prog_load_sequencer_byte_word_packer.sv
// Little-endian 8->32 packer: the first byte of a word lands in word[7:0].
// word_valid flags the byte that completes a word; word holds it from the next cycle.
module byte_word_packer
  import prog_load_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [BCNT_W-1:0] cnt_q;
  logic [WORD_W-1:0] word_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clr) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (byte_valid) begin
      word_q <= {byte_data, word_q[WORD_W-1:8]};
      cnt_q  <= cnt_q + BCNT_W'(1);
    end
  end

  assign word_valid = byte_valid && !clr && (cnt_q == BCNT_W'(WORD_BYTES - 1));
  assign word       = word_q;

endmodule

// File: rtl/prog_load_sequencer.sv
// Boot/program-load controller: in RUN the CPU owns the dmem write port; in LOAD the
// CPU is held in reset while UART words fill imem then dmem. Optional macro: PROG_TIMEOUT_EN.
module prog_load_sequencer
  import prog_load_pkg::*;
#(
  parameter int ADDR_W = 14
`ifdef PROG_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1 << 24
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  prog_load_if.slave bus,
  output logic       cpu_rst_n_o,
  output logic       upg_done_o,
  output logic       busy_o,
  output logic       err_o
);

  state_e            state_q, state_d;
  logic              start_s1, start_s2, start_d;
  logic              start_rise;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  wc_q;
  logic [LEN_W-1:0]  len_full;
  logic              last_word;
  logic              timeout;
  logic              pk_clr, pk_byte, pk_word_valid;
  logic [WORD_W-1:0] pk_word;

  // Two-flop synchroniser plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_d  <= 1'b0;
    end else begin
      start_s1 <= start_i;
      start_s2 <= start_s1;
      start_d  <= start_s2;
    end
  end

  assign start_rise = start_s2 && !start_d;
  assign len_full   = {bus.rx_data_i, len_q[7:0]};
  assign last_word  = (wc_q + LEN_W'(1)) == len_q;

  // A byte arriving during WRITE becomes byte 0 of the next word.
  assign pk_byte = bus.rx_valid_i && (state_q == ST_DATA || state_q == ST_WRITE);
  assign pk_clr  = (state_q == ST_RUN) || (state_q == ST_DONE);

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_valid (pk_byte),
    .byte_data  (bus.rx_data_i),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

`ifdef PROG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);

  logic [TO_W-1:0] idle_q;
  logic            waiting;
  logic            err_q;

  assign waiting = (state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_DATA);
  assign timeout = waiting && !bus.rx_valid_i && (idle_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (waiting && !bus.rx_valid_i) idle_q <= idle_q + TO_W'(1);
      else                            idle_q <= '0;
      if (timeout)                                 err_q <= 1'b1;
      else if (start_rise && state_q == ST_RUN)    err_q <= 1'b0;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (start_rise) state_d = ST_LEN0;
      ST_LEN0: begin
        if (timeout)               state_d = ST_DONE;
        else if (bus.rx_valid_i)   state_d = ST_LEN1;
      end
      ST_LEN1: begin
        if (timeout)               state_d = ST_DONE;
        else if (bus.rx_valid_i)   state_d = (len_full == '0) ? ST_DONE : ST_DATA;
      end
      ST_DATA: begin
        if (timeout)               state_d = ST_DONE;
        else if (pk_word_valid)    state_d = ST_WRITE;
      end
      ST_WRITE: state_d = last_word ? ST_DONE : ST_DATA;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Length capture and word counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '0;
      wc_q  <= '0;
    end else begin
      if (state_q == ST_LEN0 && bus.rx_valid_i) len_q[7:0] <= bus.rx_data_i;
      if (state_q == ST_LEN1 && bus.rx_valid_i) begin
        len_q[15:8] <= bus.rx_data_i;
        wc_q        <= '0;
      end
      if (state_q == ST_WRITE) wc_q <= wc_q + LEN_W'(1);
    end
  end

  always_comb begin
    bus.imem_wen_o = 1'b0;
    bus.dmem_wen_o = 1'b0;
    bus.mem_adr_o  = '0;
    bus.mem_dat_o  = '0;
    cpu_rst_n_o    = (state_q == ST_RUN);
    upg_done_o     = (state_q == ST_RUN);
    busy_o         = (state_q != ST_RUN);
    unique case (state_q)
      ST_RUN: begin
        bus.dmem_wen_o = bus.cpu_wen_i;
        bus.mem_adr_o  = bus.cpu_adr_i;
        bus.mem_dat_o  = bus.cpu_dat_i;
      end
      ST_WRITE: begin
        bus.mem_adr_o = wc_q[ADDR_W-1:0];
        bus.mem_dat_o = pk_word;
        if (word_in_range(wc_q, ADDR_W)) begin
          bus.imem_wen_o = !wc_q[ADDR_W];
          bus.dmem_wen_o = wc_q[ADDR_W];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prog_load_sequencer.sv
// Self-checking bench for prog_load_sequencer: RUN pass-through vector table plus
// scoreboarded LOAD sequences (imem/dmem split, dropped words, WRITE-cycle bytes, reset abort).
module tb_prog_load_sequencer;

  // Small address space keeps the imem/dmem/out-of-range load short.
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0;
  logic cpu_rst_n_o, upg_done_o, busy_o, err_o;

  prog_load_if #(.ADDR_W(ADDR_W)) bus ();

  prog_load_sequencer #(
    .ADDR_W(ADDR_W)
`ifdef PROG_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .bus         (bus),
    .cpu_rst_n_o (cpu_rst_n_o),
    .upg_done_o  (upg_done_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic              dmem;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  // Every strobe seen during LOAD must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && busy_o && (bus.imem_wen_o || bus.dmem_wen_o)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {30'd0, bus.imem_wen_o, bus.dmem_wen_o}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_sel", {30'd0, bus.imem_wen_o, bus.dmem_wen_o}, mon_e.dmem ? 32'd1 : 32'd2);
        check("wr_adr", 32'(bus.mem_adr_o), 32'(mon_e.adr));
        check("wr_dat", bus.mem_dat_o, mon_e.dat);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    tick(1);
    bus.rx_valid_i = 1'b0;
    if (gap > 1) tick(gap - 1);
  endtask

  task automatic pulse_start();
    int k;
    start_i = 1'b1;
    tick(4);
    start_i = 1'b0;
    k = 0;
    while (!busy_o && k < 10) begin
      tick(1);
      k++;
    end
    check("load_busy", 32'(busy_o), 32'd1);
    check("load_cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
    check("load_upg_done", 32'(upg_done_o), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy_o && k < 200) begin
      tick(1);
      k++;
    end
    check(name, 32'(busy_o), 32'd0);
    check({name, "_cpu_rst_n"}, 32'(cpu_rst_n_o), 32'd1);
    check({name, "_upg_done"}, 32'(upg_done_o), 32'd1);
  endtask

  task automatic run_load(input string name, input logic [31:0] ws[$], input int gap, input int tail_gap);
    logic [15:0] n;
    logic [31:0] w;
    wr_t e;
    n = 16'(ws.size());
    pulse_start();
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int i = 0; i < ws.size(); i++) begin
      w = ws[i];
      for (int b = 0; b < 4; b++) begin
        if (b == 3 && i < 2 ** (ADDR_W + 1)) begin
          e.dmem = (i >= 2 ** ADDR_W);
          e.adr  = ADDR_W'(i % (2 ** ADDR_W));
          e.dat  = w;
          exp_q.push_back(e);
        end
        send_byte(w[8*b +: 8], (b == 3) ? tail_gap : gap);
      end
    end
    wait_idle({name, "_idle"});
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic              rx_valid;
    logic              cpu_wen;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
    logic              exp_dmem_wen;
    logic [ADDR_W-1:0] exp_adr;
    logic [31:0]       exp_dat;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] words[$];

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.cpu_wen_i  = 1'b0;
    bus.cpu_adr_i  = '0;
    bus.cpu_dat_i  = '0;

    vecs[0] = '{1'b0, 1'b1, 4'h5, 32'hA5A5_A5A5, 1'b1, 4'h5, 32'hA5A5_A5A5};
    vecs[1] = '{1'b0, 1'b0, 4'hF, 32'hFFFF_FFFF, 1'b0, 4'hF, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h1234_5678, 1'b1, 4'h3, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 1'b0, 4'h0, 32'h0000_0000};
    vecs[4] = '{1'b0, 1'b1, 4'hA, 32'hDEAD_BEEF, 1'b1, 4'hA, 32'hDEAD_BEEF};

    // Reset state, held and released.
    tick(3);
    check("rst_cpu_rst_n", 32'(cpu_rst_n_o), 32'd1);
    check("rst_upg_done", 32'(upg_done_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_imem_wen", 32'(bus.imem_wen_o), 32'd0);
    rst = 1'b1;
    tick(2);

    // RUN pass-through, same cycle; rx bytes in RUN must not start anything.
    for (int i = 0; i < 5; i++) begin
      bus.rx_valid_i = vecs[i].rx_valid;
      bus.rx_data_i  = 8'h5A;
      bus.cpu_wen_i  = vecs[i].cpu_wen;
      bus.cpu_adr_i  = vecs[i].adr;
      bus.cpu_dat_i  = vecs[i].dat;
      #1;
      check("run_dmem_wen", 32'(bus.dmem_wen_o), 32'(vecs[i].exp_dmem_wen));
      check("run_adr", 32'(bus.mem_adr_o), 32'(vecs[i].exp_adr));
      check("run_dat", bus.mem_dat_o, vecs[i].exp_dat);
      check("run_imem_wen", 32'(bus.imem_wen_o), 32'd0);
      tick(1);
      check("run_busy", 32'(busy_o), 32'd0);
    end
    bus.rx_valid_i = 1'b0;

    // CPU writes are ignored while loading; keep cpu_wen_i high throughout.
    bus.cpu_wen_i = 1'b1;

    // Two imem words, bytes back-to-back (one lands in each WRITE cycle).
    words = {32'h1234_5678, 32'hDEAD_BEEF};
    run_load("two_words", words, 1, 1);
    check("two_words_err", 32'(err_o), 32'd0);

    // Zero-length load goes straight to DONE.
    words.delete();
    run_load("zero_len", words, 1, 1);

    // imem, dmem (word 16 -> dmem[0]) and out-of-range words 32, 33.
    words.delete();
    for (int i = 0; i < 34; i++) begin
      if (i == 16) words.push_back(32'hCAFE_F00D);
      else         words.push_back((32'(i) * 32'h0103_0507) ^ 32'h5A5A_0000);
    end
    run_load("span", words, 1, 1);

    // Spaced bytes, with the first byte of each next word landing in WRITE.
    words = {32'h0102_0304, 32'hA0B0_C0D0, 32'hFFEE_DDCC};
    run_load("spaced", words, 4, 1);

    // Reset after three data bytes: immediate RUN, no strobe, partial word discarded.
    pulse_start();
    send_byte(8'h02, 1);
    send_byte(8'h00, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_cpu_rst_n", 32'(cpu_rst_n_o), 32'd1);
    tick(2);
    rst = 1'b1;
    tick(2);
    words = {32'h0BAD_CAFE};
    run_load("after_abort", words, 1, 1);

`ifdef PROG_TIMEOUT_EN
    begin
      int k;
      pulse_start();
      send_byte(8'h03, 1);
      send_byte(8'h00, 1);
      k = 0;
      while (busy_o && k < 300) begin
        tick(1);
        k++;
      end
      check("timeout_window", 32'(k >= 95 && k <= 105), 32'd1);
      check("timeout_err", 32'(err_o), 32'd1);
      pulse_start();
      check("timeout_err_clr", 32'(err_o), 32'd0);
      send_byte(8'h00, 1);
      send_byte(8'h00, 1);
      wait_idle("timeout_recover");
    end
`endif

    bus.cpu_wen_i = 1'b0;
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
